enc16_scan: RTL and testbench

- Sequential 16-to-4 priority encoder. It is the inverse of the team's 4-to-16 enabled decoder.
- Captures a 16-line request vector on a load strobe, then emits the 4-bit code of every active line, lowest index first.
- Each code is presented with a valid/ack handshake. A done pulse follows the last code.
- Sits downstream of decoder-driven request lines: it turns one-hot or multi-hot line vectors back into binary indices for a consumer.

---
 rtl/enc16_scan_if.sv | 33 +++
 rtl/enc16_scan.sv | 156 +++++++++++++++
 tb/tb_enc16_scan.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/enc16_scan_if.sv
// enc16_scan_if: request/code handshake bundle for the 16-to-4 scanning encoder.
//   en    - global enable, 0 freezes the encoder
//   load  - capture strobe for D
//   D     - request lines, D[i] high means line i is active
//   ack   - consumer accepts the current code
//   code  - binary index of the current line
//   valid - code is valid, held until ack
//   busy  - encoder is scanning or finishing
//   done  - one-cycle pulse after the last code
//   none  - one-cycle pulse with done when the captured vector was zero
// master: the side that drives requests and consumes codes.
// slave:  the encoder itself.
interface enc16_scan_if;
  logic        en;
  logic        load;
  logic [0:15] D;
  logic        ack;
  logic [3:0]  code;
  logic        valid;
  logic        busy;
  logic        done;
  logic        none;

  modport master (
    output en, load, D, ack,
    input  code, valid, busy, done, none
  );

  modport slave (
    input  en, load, D, ack,
    output code, valid, busy, done, none
  );
endinterface

// File: rtl/enc16_scan.sv
// enc16_scan: sequential 16-to-4 priority encoder.
// Captures a request vector on load, then presents the index of every active
// line through a valid/ack handshake, one code per accepted ack, and finishes
// with a one-cycle done pulse (plus none when the vector was all-zero).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - enc16_scan_if.slave (en, load, D, ack in; code, valid, busy,
//           done, none out; all outputs registered)
// Build option:
//   ENC_MSB_FIRST_EN - when defined, line 15 has highest priority and codes
//                      are emitted in descending order; otherwise line 0 is
//                      highest and codes are emitted in ascending order.
module enc16_scan #(
  parameter int N_LINES = 16,
  parameter int CODE_W  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  enc16_scan_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [N_LINES-1:0]  pending_r;
  logic [CODE_W-1:0]   code_r;
  logic                valid_r;
  logic                busy_r;
  logic                done_r;
  logic                none_r;
  logic                zero_vec_r;

  logic [N_LINES-1:0]  d_vec_s;
  logic [N_LINES-1:0]  pend_left_s;
  logic [CODE_W-1:0]   first_code_s;
  logic [CODE_W-1:0]   next_code_s;

  // Highest-priority set line of v; the scan direction sets the priority.
  function automatic logic [CODE_W-1:0] pick_line(input logic [N_LINES-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
`ifdef ENC_MSB_FIRST_EN
    // Ascending walk: the last hit is the highest index.
    for (int i = 0; i < N_LINES; i++) begin
      if (v[i]) idx = CODE_W'(i);
      else      idx = idx;
    end
`else
    // Descending walk: the last hit is the lowest index.
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (v[i]) idx = CODE_W'(i);
      else      idx = idx;
    end
`endif
    return idx;
  endfunction

  // Normalise D so bit i is line i, and precompute the vector after an ack.
  always_comb begin
    d_vec_s = '0;
    for (int i = 0; i < N_LINES; i++) begin
      d_vec_s[i] = bus.D[i];
    end
    pend_left_s  = pending_r & ~({{(N_LINES-1){1'b0}}, 1'b1} << code_r);
    first_code_s = pick_line(d_vec_s);
    next_code_s  = pick_line(pend_left_s);
  end

  // Scan state machine with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pending_r  <= '0;
      code_r     <= '0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      none_r     <= 1'b0;
      zero_vec_r <= 1'b0;
    end else if (!bus.en) begin
      // Frozen: everything holds except the pulses. Clearing done_r here
      // leaves DONE waiting to re-raise the pulse once en returns.
      done_r <= 1'b0;
      none_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.load) begin
            pending_r <= d_vec_s;
            busy_r    <= 1'b1;
            if (d_vec_s != '0) begin
              state_r    <= ST_SCAN;
              valid_r    <= 1'b1;
              code_r     <= first_code_s;
              zero_vec_r <= 1'b0;
            end else begin
              state_r    <= ST_DONE;
              done_r     <= 1'b1;
              none_r     <= 1'b1;
              zero_vec_r <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (bus.ack && valid_r) begin
            pending_r <= pend_left_s;
            if (pend_left_s != '0) begin
              code_r <= next_code_s;
            end else begin
              valid_r <= 1'b0;
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              none_r  <= 1'b0;
            end
          end else begin
            state_r <= ST_SCAN;
          end
        end
        ST_DONE: begin
          // done_r high means the pulse has been shown with en=1; leave.
          if (done_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            none_r  <= 1'b0;
          end else begin
            done_r <= 1'b1;
            none_r <= zero_vec_r;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          pending_r <= '0;
          valid_r   <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          none_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.code  = code_r;
  assign bus.valid = valid_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.none  = none_r;

endmodule

// File: tb/tb_enc16_scan.sv
// tb_enc16_scan: self-checking bench for enc16_scan.
// The reference model turns a line vector into the ordered list of set
// indices; directed and randomized vectors are scanned against it.
module tb_enc16_scan;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   exp_q[$];

  enc16_scan_if bus ();

  enc16_scan dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [15:0] lines);
    for (int i = 0; i < 16; i++) bus.D[i] = lines[i];
  endtask

  // Reference: indices of set lines in emission order.
  task automatic fill_exp(input logic [15:0] lines);
    exp_q.delete();
`ifdef ENC_MSB_FIRST_EN
    for (int i = 15; i >= 0; i--) if (lines[i]) exp_q.push_back(i);
`else
    for (int i = 0; i < 16; i++) if (lines[i]) exp_q.push_back(i);
`endif
  endtask

  task automatic check_idle_out(input string tag);
    chk({tag, "_code"},  {12'h000, bus.code}, 16'h0000);
    chk({tag, "_valid"}, {15'h0, bus.valid}, 16'h0000);
    chk({tag, "_busy"},  {15'h0, bus.busy},  16'h0000);
    chk({tag, "_done"},  {15'h0, bus.done},  16'h0000);
    chk({tag, "_none"},  {15'h0, bus.none},  16'h0000);
  endtask

  // Load a vector and consume all codes, with up to max_stall idle cycles
  // before each ack.
  task automatic run_vec(input string tag, input logic [15:0] lines, input int max_stall);
    int c;
    int stall;
    fill_exp(lines);
    set_d(lines);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    set_d(16'($urandom));
    if (exp_q.size() == 0) begin
      chk({tag, "_zvalid"}, {15'h0, bus.valid}, 16'h0000);
      chk({tag, "_zdone"},  {15'h0, bus.done},  16'h0001);
      chk({tag, "_znone"},  {15'h0, bus.none},  16'h0001);
      chk({tag, "_zbusy"},  {15'h0, bus.busy},  16'h0001);
    end else begin
      while (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        stall = $urandom_range(0, max_stall);
        if (stall > 0) bus.ack = 1'b0;
        for (int s = 0; s < stall; s++) begin
          chk({tag, "_hold"}, {12'h000, bus.code}, 16'(c));
          tick();
        end
        chk({tag, "_valid"}, {15'h0, bus.valid}, 16'h0001);
        chk({tag, "_code"},  {12'h000, bus.code}, 16'(c));
        chk({tag, "_ndone"}, {15'h0, bus.done},  16'h0000);
        bus.ack = 1'b1;
        tick();
      end
      chk({tag, "_evalid"}, {15'h0, bus.valid}, 16'h0000);
      chk({tag, "_done"},   {15'h0, bus.done},  16'h0001);
      chk({tag, "_none"},   {15'h0, bus.none},  16'h0000);
      chk({tag, "_dbusy"},  {15'h0, bus.busy},  16'h0001);
    end
    bus.ack = 1'b0;
    tick();
    chk({tag, "_pdone"}, {15'h0, bus.done}, 16'h0000);
    chk({tag, "_pnone"}, {15'h0, bus.none}, 16'h0000);
    chk({tag, "_pbusy"}, {15'h0, bus.busy}, 16'h0000);
  endtask

  initial begin
    logic [15:0] v;
    int c;
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.load = 1'b0;
    bus.ack  = 1'b0;
    set_d(16'h0000);
    tick();
    tick();
    check_idle_out("reset");
    rst_n = 1'b1;
    tick();

    // Single lines.
    for (int k = 0; k < 16; k++) begin
      v = 16'h0000;
      v[k] = 1'b1;
      run_vec("single", v, 0);
    end

    // Multi-hot burst: lines 3, 9, 14.
    v = 16'h0000;
    v[3] = 1'b1; v[9] = 1'b1; v[14] = 1'b1;
    run_vec("burst", v, 0);

    // Zero vector.
    run_vec("zero", 16'h0000, 0);

    // Stall with a second load that must be ignored.
    v = 16'h0000;
    v[0] = 1'b1; v[15] = 1'b1;
    fill_exp(v);
    set_d(v);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    c = exp_q.pop_front();
    for (int s = 0; s < 5; s++) begin
      chk("stall_valid", {15'h0, bus.valid}, 16'h0001);
      chk("stall_code", {12'h000, bus.code}, 16'(c));
      if (s == 2) begin
        set_d(16'h00F0);
        bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      tick();
    end
    bus.load = 1'b0;
    bus.ack = 1'b1;
    tick();
    c = exp_q.pop_front();
    chk("stall_code2", {12'h000, bus.code}, 16'(c));
    chk("stall_valid2", {15'h0, bus.valid}, 16'h0001);
    tick();
    chk("stall_done", {15'h0, bus.done}, 16'h0001);
    bus.ack = 1'b0;
    tick();
    chk("stall_busy", {15'h0, bus.busy}, 16'h0000);

    // Enable freeze mid-scan of an all-ones vector.
    fill_exp(16'hFFFF);
    set_d(16'hFFFF);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.ack = 1'b1;
    for (int s = 0; s < 3; s++) begin
      c = exp_q.pop_front();
      chk("frz_pre", {12'h000, bus.code}, 16'(c));
      tick();
    end
    bus.en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk("frz_code", {12'h000, bus.code}, 16'(exp_q[0]));
      chk("frz_valid", {15'h0, bus.valid}, 16'h0001);
      chk("frz_busy", {15'h0, bus.busy}, 16'h0001);
    end
    bus.en = 1'b1;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      chk("frz_resume", {12'h000, bus.code}, 16'(c));
      tick();
    end
    chk("frz_done", {15'h0, bus.done}, 16'h0001);
    bus.ack = 1'b0;
    tick();

    // Randomized vectors with random stalls.
    for (int r = 0; r < 12; r++) begin
      v = 16'($urandom);
      if (r == 5) v = 16'h0000;
      run_vec("rand", v, 2);
    end

    // Reset while code 7 is valid.
    fill_exp(16'hFFFF);
    set_d(16'hFFFF);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    while (exp_q[0] != 7) begin
      void'(exp_q.pop_front());
      bus.ack = 1'b1;
      tick();
    end
    bus.ack = 1'b0;
    chk("rst_pre_code", {12'h000, bus.code}, 16'h0007);
    rst_n = 1'b0;
    #1;
    check_idle_out("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    v = 16'h0000;
    v[2] = 1'b1;
    run_vec("post_rst", v, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
